vx_lane_split: RTL and testbench
================================

# vx_lane_split

Splits one full-width execute bundle (all `NUM_THREADS` lanes) from the issue/dispatch side into a sequence of `NUM_LANES`-wide packets for a functional unit's execute input. Each packet carries its batch index `pid` and start/end-of-packet flags `sop`/`eop`. The block sits directly upstream of a narrow execute port and is the producer of its `pid`/`sop`/`eop` fields. It holds one bundle and issues at most one batch per cycle under valid/ready backpressure.

## Interface
Parameters:
- `NUM_THREADS`, 8: lanes in the incoming bundle.
- `NUM_LANES`, 2: lanes per outgoing packet; `NUM_THREADS % NUM_LANES == 0` is required.
- `XLEN`, 32: operand width.
- `HDR_WIDTH`, 128: packed width of the per-instruction header. The header carries uuid, wid, op_type, op_mod, wb, use_PC, use_imm, PC, imm, rd, tid and the m_* fields, and passes through unmodified.
- Derived: `BATCHES = NUM_THREADS/NUM_LANES`; `PID_WIDTH = LOG2UP(BATCHES)`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  bundle valid.
- `in_hdr`  in  HDR_WIDTH  header.
- `in_tmask`  in  NUM_THREADS  thread mask.
- `in_rs1_data`, `in_rs2_data`, `in_rs3_data`  in  NUM_THREADS*XLEN  operands; lane i occupies bits [i*XLEN +: XLEN].
- `in_ready`  out  1  bundle accepted when `in_valid & in_ready`.
- `out_valid`  out  1  packet valid.
- `out_hdr`  out  HDR_WIDTH  header copy.
- `out_tmask`  out  NUM_LANES  tmask slice for the current batch.
- `out_rs1_data`, `out_rs2_data`, `out_rs3_data`  out  NUM_LANES*XLEN  operand slices.
- `out_pid`  out  PID_WIDTH  batch index.
- `out_sop`, `out_eop`  out  1  first / last packet of the bundle.
- `out_ready`  in  1  packet consumed when `out_valid & out_ready`.

## Operation
- Two states:
  - IDLE: no bundle held.
  - ISSUE: bundle held in a holding register, and `pid` points at the current batch.
- Batch k covers lanes [k*NUM_LANES, (k+1)*NUM_LANES). Outputs are driven combinationally from the holding register slice selected by `pid`.
- `out_valid = (state == ISSUE)`.
- `in_ready = (state == IDLE) | (out_valid & out_ready & out_eop)`.
- Input fire: capture the bundle, set `pid` to the first batch to issue, set the `sop` flag, and go to ISSUE. This applies from IDLE or on the same cycle the last packet fires.
- Output fire, not last: `pid` advances to the next batch to issue and `sop` clears.
- Output fire, last, no input fire: go to IDLE.
- `out_eop` is 1 when no later batch will be issued.
- `NUM_LANES == NUM_THREADS`: a single batch; `pid = 0` and `sop = eop = 1` always.
- Reset mid-bundle: the bundle is dropped with no partial completion.

## Timing
- Reset values: state IDLE, `pid` 0, holding register 0. Outputs `out_valid` 0, `out_pid` 0, `out_sop` 0, `out_eop` 0, `out_tmask`/`out_hdr`/`out_rs*_data` 0. `in_ready` is 1 after reset.
- Latency: an input fire in cycle N gives `out_valid` = 1 in cycle N+1.
- Throughput: one packet per cycle while `out_ready` = 1.
- Back-to-back bundles have no bubble: the last packet of bundle A and the input fire of bundle B happen in the same cycle.
- `out_valid` and all `out_*` fields are stable while `out_valid & ~out_ready`.
- Number of packets per bundle equals the number of batches issued. Without skipping, that is always `BATCHES`.

## Configuration
- `LANE_SKIP_EMPTY_EN` defined:
  - Batches whose tmask slice is all-zero are never issued.
  - First batch = lowest nonzero batch; next batch = next higher nonzero batch.
  - `eop` is set when no higher nonzero batch exists.
  - A bundle with all-zero `in_tmask` issues exactly one packet: `pid` 0, `sop = eop = 1`, tmask 0.
- `LANE_SKIP_EMPTY_EN` undefined: all `BATCHES` batches are issued in order 0..BATCHES-1, regardless of tmask.

## Test plan
- Single bundle, `in_tmask` = 8'hFF, `out_ready` = 1 held high → 4 packets on consecutive cycles:
  - `pid` 0,1,2,3.
  - `sop` on pid 0 only; `eop` on pid 3 only.
  - tmask 2'b11 each.
  - `out_rs1_data` equal to lanes 2k, 2k+1.
- Backpressure: `out_ready` low for 3 cycles at pid 1 → pid 1 and its data are held stable; `in_ready` = 0 throughout.
- Back-to-back: two bundles, the second presented with `in_valid` held → 8 packets with no idle cycle; `in_ready` pulses only on the pid 3 fire.
- Skip enabled, `in_tmask` = 8'b0011_0000 → one packet: `pid` 2, `sop` = 1, `eop` = 1, tmask 2'b11. Skip disabled, same mask → 4 packets: pid 2 carries 2'b11, the others carry 2'b00.
- Skip enabled, `in_tmask` = 0 → one packet: `pid` 0, `sop = eop = 1`.
- Assert `reset` during pid 2 → next cycle `out_valid` = 0 and `in_ready` = 1. A new bundle issued afterwards starts at `pid` 0 with `sop` = 1.

Source files
------------

// File: rtl/vx_lane_split.sv
// Splits one NUM_THREADS-wide execute bundle into NUM_LANES-wide packets tagged pid/sop/eop.
// Optional LANE_SKIP_EMPTY_EN: batches with an all-zero tmask slice are not issued.
module vx_lane_split #(
  parameter int unsigned NUM_THREADS = 8,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned HDR_WIDTH   = 128,
  localparam int unsigned BATCHES    = NUM_THREADS / NUM_LANES,
  localparam int unsigned PID_WIDTH  = (BATCHES > 1) ? $clog2(BATCHES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [HDR_WIDTH-1:0]         in_hdr,
  input  logic [NUM_THREADS-1:0]       in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0]  in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0]  in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0]  in_rs3_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [HDR_WIDTH-1:0]         out_hdr,
  output logic [NUM_LANES-1:0]         out_tmask,
  output logic [NUM_LANES*XLEN-1:0]    out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]    out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]    out_rs3_data,
  output logic [PID_WIDTH-1:0]         out_pid,
  output logic                         out_sop,
  output logic                         out_eop,
  input  logic                         out_ready
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                       state_q, state_d;
  logic [PID_WIDTH-1:0]         pid_q, pid_d;
  logic                         sop_q, sop_d;
  logic [HDR_WIDTH-1:0]         hdr_q, hdr_d;
  logic [NUM_THREADS-1:0]       tmask_q, tmask_d;
  logic [NUM_THREADS*XLEN-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;

  logic [PID_WIDTH-1:0]         first_pid, next_pid;
  logic                         is_last;
  logic                         in_fire, out_fire;

`ifdef LANE_SKIP_EMPTY_EN
  logic [BATCHES-1:0] in_nz, hold_nz;
  logic               has_next;

  // Scan high-to-low so the last hit is the lowest qualifying batch.
  always_comb begin
    in_nz     = '0;
    hold_nz   = '0;
    first_pid = '0;
    next_pid  = '0;
    has_next  = 1'b0;
    for (int unsigned i = 0; i < BATCHES; i++) begin
      in_nz[i]   = |in_tmask[i*NUM_LANES +: NUM_LANES];
      hold_nz[i] = |tmask_q[i*NUM_LANES +: NUM_LANES];
    end
    for (int unsigned i = 0; i < BATCHES; i++) begin
      if (in_nz[BATCHES-1-i]) first_pid = PID_WIDTH'(BATCHES-1-i);
      if (hold_nz[BATCHES-1-i] && ((BATCHES-1-i) > 32'(pid_q))) begin
        next_pid = PID_WIDTH'(BATCHES-1-i);
        has_next = 1'b1;
      end
    end
    is_last = ~has_next;
  end
`else
  always_comb begin
    first_pid = '0;
    next_pid  = pid_q + PID_WIDTH'(1);
    is_last   = (pid_q == PID_WIDTH'(BATCHES-1));
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pid_q   <= '0;
      sop_q   <= 1'b0;
      hdr_q   <= '0;
      tmask_q <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      sop_q   <= sop_d;
      hdr_q   <= hdr_d;
      tmask_q <= tmask_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rs3_q   <= rs3_d;
    end
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Input fire takes priority so a new bundle loads on its predecessor's last packet.
  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    sop_d   = sop_q;
    hdr_d   = hdr_q;
    tmask_d = tmask_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rs3_d   = rs3_q;
    if (in_fire) begin
      state_d = ISSUE;
      pid_d   = first_pid;
      sop_d   = 1'b1;
      hdr_d   = in_hdr;
      tmask_d = in_tmask;
      rs1_d   = in_rs1_data;
      rs2_d   = in_rs2_data;
      rs3_d   = in_rs3_data;
    end else if (out_fire) begin
      if (is_last) begin
        state_d = IDLE;
        pid_d   = '0;
        sop_d   = 1'b0;
      end else begin
        pid_d   = next_pid;
        sop_d   = 1'b0;
      end
    end
  end

  always_comb begin
    out_valid    = (state_q == ISSUE);
    out_sop      = out_valid & sop_q;
    out_eop      = out_valid & is_last;
    in_ready     = (state_q == IDLE) | (out_valid & out_ready & out_eop);
    out_pid      = pid_q;
    out_hdr      = hdr_q;
    out_tmask    = tmask_q[pid_q*NUM_LANES +: NUM_LANES];
    out_rs1_data = rs1_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    out_rs2_data = rs2_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];
    out_rs3_data = rs3_q[pid_q*NUM_LANES*XLEN +: NUM_LANES*XLEN];
  end

endmodule

// File: tb/tb_vx_lane_split.sv
// Directed bench for vx_lane_split at NUM_THREADS=8, NUM_LANES=2; expectations follow LANE_SKIP_EMPTY_EN.
module tb_vx_lane_split;

  localparam int unsigned NT = 8;
  localparam int unsigned NL = 2;
  localparam int unsigned XL = 32;
  localparam int unsigned HW = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [HW-1:0]     in_hdr;
  logic [NT-1:0]     in_tmask;
  logic [NT*XL-1:0]  in_rs1_data, in_rs2_data, in_rs3_data;
  logic              in_ready;
  logic              out_valid;
  logic [HW-1:0]     out_hdr;
  logic [NL-1:0]     out_tmask;
  logic [NL*XL-1:0]  out_rs1_data, out_rs2_data, out_rs3_data;
  logic [1:0]        out_pid;
  logic              out_sop, out_eop;
  logic              out_ready;

  int errors = 0;
  int checks = 0;

  vx_lane_split #(.NUM_THREADS(NT), .NUM_LANES(NL), .XLEN(XL), .HDR_WIDTH(HW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_hdr(in_hdr), .in_tmask(in_tmask),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs3_data(in_rs3_data),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_hdr(out_hdr), .out_tmask(out_tmask),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rs3_data(out_rs3_data),
    .out_pid(out_pid), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled well after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bundle(input logic [HW-1:0] hdr, input logic [NT-1:0] tm, input logic [31:0] base);
    in_hdr   = hdr;
    in_tmask = tm;
    for (int i = 0; i < NT; i++) begin
      in_rs1_data[i*XL +: XL] = base + 32'(i);
      in_rs2_data[i*XL +: XL] = base + 32'h100 + 32'(i);
      in_rs3_data[i*XL +: XL] = base + 32'h200 + 32'(i);
    end
  endtask

  task automatic expect_pkt(input string tag, input int k, input logic sop, input logic eop,
                            input logic [1:0] tm, input logic [31:0] base, input logic [HW-1:0] hdr);
    logic [63:0] e1, e2, e3;
    e1 = {base + 32'(2*k+1),           base + 32'(2*k)};
    e2 = {base + 32'h100 + 32'(2*k+1), base + 32'h100 + 32'(2*k)};
    e3 = {base + 32'h200 + 32'(2*k+1), base + 32'h200 + 32'(2*k)};
    #1;
    check({tag, ".valid"}, 128'(out_valid), 128'(1'b1));
    check({tag, ".pid"},   128'(out_pid),   128'(k));
    check({tag, ".sop"},   128'(out_sop),   128'(sop));
    check({tag, ".eop"},   128'(out_eop),   128'(eop));
    check({tag, ".tmask"}, 128'(out_tmask), 128'(tm));
    check({tag, ".hdr"},   out_hdr,         hdr);
    check({tag, ".rs1"},   128'(out_rs1_data), 128'(e1));
    check({tag, ".rs2"},   128'(out_rs2_data), 128'(e2));
    check({tag, ".rs3"},   128'(out_rs3_data), 128'(e3));
  endtask

  localparam logic [HW-1:0] HA = 128'hA0A0_0001_0000_0000_0000_0000_0000_00A1;
  localparam logic [HW-1:0] HB = 128'hB0B0_0002_0000_0000_0000_0000_0000_00B2;
  localparam logic [HW-1:0] HC = 128'hC0C0_0003_0000_0000_0000_0000_0000_00C3;

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_hdr = '0; in_tmask = '0; in_rs1_data = '0; in_rs2_data = '0; in_rs3_data = '0;
    step(); step();
    check("rst.valid", 128'(out_valid), 128'(0));
    check("rst.pid",   128'(out_pid),   128'(0));
    check("rst.sop",   128'(out_sop),   128'(0));
    check("rst.eop",   128'(out_eop),   128'(0));
    check("rst.tmask", 128'(out_tmask), 128'(0));
    check("rst.hdr",   out_hdr,         128'(0));
    check("rst.rs1",   128'(out_rs1_data), 128'(0));
    check("rst.inrdy", 128'(in_ready),  128'(1));
    reset = 1'b0;
    step();

    // Full mask, ready held high: four consecutive packets.
    set_bundle(HA, 8'hFF, 32'h1000_0000);
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check("t1.inrdy_idle", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_pkt($sformatf("t1.p%0d", k), k, k == 0, k == 3, 2'b11, 32'h1000_0000, HA);
      check($sformatf("t1.p%0d.inrdy", k), 128'(in_ready), 128'(k == 3));
      step();
    end
    #1 check("t1.done.valid", 128'(out_valid), 128'(0));

    // Backpressure at pid 1.
    set_bundle(HB, 8'hFF, 32'h2000_0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    expect_pkt("t2.p0", 0, 1'b1, 1'b0, 2'b11, 32'h2000_0000, HB);
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      expect_pkt($sformatf("t2.hold%0d", c), 1, 1'b0, 1'b0, 2'b11, 32'h2000_0000, HB);
      check($sformatf("t2.hold%0d.inrdy", c), 128'(in_ready), 128'(0));
      step();
    end
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      expect_pkt($sformatf("t2.p%0d", k), k, 1'b0, k == 3, 2'b11, 32'h2000_0000, HB);
      step();
    end
    #1 check("t2.done.valid", 128'(out_valid), 128'(0));

    // Back-to-back: bundle C waits on in_valid while A drains.
    set_bundle(HA, 8'hFF, 32'h3000_0000);
    in_valid = 1'b1;
    step();
    set_bundle(HC, 8'hFF, 32'h4000_0000);
    for (int j = 0; j < 8; j++) begin
      expect_pkt($sformatf("t3.p%0d", j), j % 4, (j % 4) == 0, (j % 4) == 3, 2'b11,
                 (j < 4) ? 32'h3000_0000 : 32'h4000_0000, (j < 4) ? HA : HC);
      check($sformatf("t3.p%0d.inrdy", j), 128'(in_ready), 128'((j % 4) == 3));
      step();
      if (j == 3) in_valid = 1'b0;
    end
    #1 check("t3.done.valid", 128'(out_valid), 128'(0));

    // Sparse mask: only batch 2 populated.
    set_bundle(HB, 8'b0011_0000, 32'h5000_0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef LANE_SKIP_EMPTY_EN
    expect_pkt("t4.only", 2, 1'b1, 1'b1, 2'b11, 32'h5000_0000, HB);
    step();
`else
    for (int k = 0; k < 4; k++) begin
      expect_pkt($sformatf("t4.p%0d", k), k, k == 0, k == 3, (k == 2) ? 2'b11 : 2'b00, 32'h5000_0000, HB);
      step();
    end
`endif
    #1 check("t4.done.valid", 128'(out_valid), 128'(0));

    // Empty mask.
    set_bundle(HC, 8'h00, 32'h6000_0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef LANE_SKIP_EMPTY_EN
    expect_pkt("t5.only", 0, 1'b1, 1'b1, 2'b00, 32'h6000_0000, HC);
    step();
`else
    for (int k = 0; k < 4; k++) begin
      expect_pkt($sformatf("t5.p%0d", k), k, k == 0, k == 3, 2'b00, 32'h6000_0000, HC);
      step();
    end
`endif
    #1 check("t5.done.valid", 128'(out_valid), 128'(0));

    // Reset while pid 2 is pending, then a fresh bundle.
    set_bundle(HA, 8'hFF, 32'h7000_0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    expect_pkt("t6.pre", 2, 1'b0, 1'b0, 2'b11, 32'h7000_0000, HA);
    reset = 1'b1;
    step();
    check("t6.rst.valid", 128'(out_valid), 128'(0));
    check("t6.rst.inrdy", 128'(in_ready),  128'(1));
    check("t6.rst.pid",   128'(out_pid),   128'(0));
    reset = 1'b0;
    step();
    set_bundle(HB, 8'hFF, 32'h8000_0000);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_pkt($sformatf("t6.p%0d", k), k, k == 0, k == 3, 2'b11, 32'h8000_0000, HB);
      step();
    end
    #1 check("t6.done.valid", 128'(out_valid), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
